// File: rtl/pa_maxpool_unit.sv
// Streaming 2x2 / stride-2 max-pool stage with argmax capture (forward pass)
// and argmax-routed error expansion (backward pass).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start_fp / start_bp
// S_FP_RUN  | accepting IMG_W*IMG_H activations, emitting pooled windows
// S_BP_LOAD | accepting one pooled-layer error per window
// S_BP_EMIT | emitting IMG_W*IMG_H expanded errors, one per cycle
module pa_maxpool_unit #(
   parameter int BIT_WIDTH = 32,
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_fp,
   input  logic                 start_bp,
   input  logic                 in_valid,
   input  logic [BIT_WIDTH-1:0] in_data,
   input  logic                 err_in_valid,
   input  logic [BIT_WIDTH-1:0] err_in_data,
   output logic                 in_ready,
   output logic                 pool_valid,
   output logic [BIT_WIDTH-1:0] pool_data,
   output logic [1:0]           pool_idx,
   output logic                 err_out_valid,
   output logic [BIT_WIDTH-1:0] err_out_data,
   output logic                 done_FP,
   output logic                 done_BP
);

   localparam int HALF_W = IMG_W / 2;
   localparam int N_WIN  = (IMG_W / 2) * (IMG_H / 2);
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = $clog2(IMG_H);
   localparam int WW     = $clog2(N_WIN);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [WW-1:0] WIN_LAST = WW'(N_WIN - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FP_RUN  = 2'd1;
   localparam logic [1:0] S_BP_LOAD = 2'd2;
   localparam logic [1:0] S_BP_EMIT = 2'd3;

   logic [1:0]           state;
   logic                 fp_complete;
   logic [RW-1:0]        row, row_nxt;
   logic [CW-1:0]        col, col_nxt;
   logic [WW-1:0]        load_cnt;

   // Working storage; never reset because fp_complete gates every read of it.
   logic [BIT_WIDTH-1:0] prev_val;
   logic [BIT_WIDTH-1:0] lb_val     [HALF_W];
   logic                 lb_idx     [HALF_W];
   logic [1:0]           argmax_mem [N_WIN];
   logic [BIT_WIDTH-1:0] err_buf    [N_WIN];

   logic [CW-2:0]        lb_addr;
   logic [WW-1:0]        cur_win;
   logic                 pair_gt, bot_gt;
   logic [BIT_WIDTH-1:0] pair_val, win_val;
   logic [1:0]           win_idx;
   logic                 fp_accept, err_accept, is_last_px, emit_hit;

   // Strict sign-magnitude greater-than on raw bits; +0 and -0 compare equal.
   function automatic logic fgt(input logic [BIT_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] b);
      logic a_z, b_z;
      a_z = (a[BIT_WIDTH-2:0] == '0);
      b_z = (b[BIT_WIDTH-2:0] == '0);
      if (a_z && b_z) return 1'b0;
      if (a[BIT_WIDTH-1] != b[BIT_WIDTH-1]) return ~a[BIT_WIDTH-1];
      if (a[BIT_WIDTH-1]) return a[BIT_WIDTH-2:0] < b[BIT_WIDTH-2:0];
      return a[BIT_WIDTH-2:0] > b[BIT_WIDTH-2:0];
   endfunction

   assign in_ready   = (state == S_FP_RUN) || (state == S_BP_LOAD);
   assign fp_accept  = (state == S_FP_RUN) && in_valid;
   assign err_accept = (state == S_BP_LOAD) && err_in_valid;
   assign is_last_px = (row == ROW_LAST) && (col == COL_LAST);
   assign lb_addr    = col[CW-1:1];
   assign cur_win    = WW'(32'(row[RW-1:1]) * HALF_W + 32'(col[CW-1:1]));

   // Window comparator tree: right/bottom only win on strictly greater values,
   // so ties fall to the earlier raster position.
   always_comb begin
      pair_gt  = fgt(in_data, prev_val);
      pair_val = pair_gt ? in_data : prev_val;
      bot_gt   = fgt(pair_val, lb_val[lb_addr]);
      win_val  = bot_gt ? pair_val : lb_val[lb_addr];
      win_idx  = bot_gt ? {1'b1, pair_gt} : {1'b0, lb_idx[lb_addr]};
      emit_hit = (argmax_mem[cur_win] == {row[0], col[0]});
   end

   // Row-major pixel counter advance shared by FP_RUN and BP_EMIT.
   always_comb begin
      col_nxt = col + 1'b1;
      row_nxt = row;
      if (col == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
      end
   end

   // Sequencer FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         fp_complete   <= 1'b0;
         row           <= '0;
         col           <= '0;
         load_cnt      <= '0;
         pool_valid    <= 1'b0;
         pool_data     <= '0;
         pool_idx      <= 2'd0;
         err_out_valid <= 1'b0;
         err_out_data  <= '0;
         done_FP       <= 1'b0;
         done_BP       <= 1'b0;
      end else begin
         pool_valid    <= 1'b0;
         err_out_valid <= 1'b0;
         done_FP       <= 1'b0;
         done_BP       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_fp) begin
                  state       <= S_FP_RUN;
                  fp_complete <= 1'b0;
                  row         <= '0;
                  col         <= '0;
               end else if (start_bp && fp_complete) begin
                  state    <= S_BP_LOAD;
                  load_cnt <= '0;
               end
            end
            S_FP_RUN: begin
               if (in_valid) begin
                  row <= row_nxt;
                  col <= col_nxt;
                  if (row[0] && col[0]) begin
                     pool_valid <= 1'b1;
                     pool_data  <= win_val;
                     pool_idx   <= win_idx;
                  end
                  if (is_last_px) begin
                     fp_complete <= 1'b1;
                     done_FP     <= 1'b1;
                     state       <= S_IDLE;
                  end
               end
            end
            S_BP_LOAD: begin
               if (err_in_valid) begin
                  load_cnt <= load_cnt + 1'b1;
                  if (load_cnt == WIN_LAST) begin
                     state <= S_BP_EMIT;
                     row   <= '0;
                     col   <= '0;
                  end
               end
            end
            S_BP_EMIT: begin
               err_out_valid <= 1'b1;
               err_out_data  <= emit_hit ? err_buf[cur_win] : '0;
               row           <= row_nxt;
               col           <= col_nxt;
               if (is_last_px) begin
                  done_BP <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pair hold, line buffer, argmax memory and error buffer writes.
   always_ff @(posedge clk) begin
      if (fp_accept) begin
         if (!col[0]) begin
            prev_val <= in_data;
         end else if (!row[0]) begin
            lb_val[lb_addr] <= pair_val;
            lb_idx[lb_addr] <= pair_gt;
         end else begin
            argmax_mem[cur_win] <= win_idx;
         end
      end
      if (err_accept) err_buf[load_cnt] <= err_in_data;
   end

endmodule

// File: tb/tb_pa_maxpool_unit.sv
// Directed bench for pa_maxpool_unit: ramp and special-value forward passes,
// argmax-routed backward passes, stalls, start arbitration and resets.
module tb_pa_maxpool_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_fp = 1'b0, start_bp = 1'b0;
   logic        in_valid = 1'b0, err_in_valid = 1'b0;
   logic [31:0] in_data = '0, err_in_data = '0;
   logic        in_ready, pool_valid, err_out_valid, done_FP, done_BP;
   logic [31:0] pool_data, err_out_data;
   logic [1:0]  pool_idx;

   always #5 clk = ~clk;

   pa_maxpool_unit #(.BIT_WIDTH(32), .IMG_W(28), .IMG_H(28)) dut (
      .clk(clk), .rst(rst), .start_fp(start_fp), .start_bp(start_bp),
      .in_valid(in_valid), .in_data(in_data),
      .err_in_valid(err_in_valid), .err_in_data(err_in_data),
      .in_ready(in_ready), .pool_valid(pool_valid), .pool_data(pool_data), .pool_idx(pool_idx),
      .err_out_valid(err_out_valid), .err_out_data(err_out_data),
      .done_FP(done_FP), .done_BP(done_BP)
   );

   int          n_cmp = 0, n_fail = 0;
   logic [31:0] img [0:783];
   logic [31:0] pd  [0:1023];
   logic [1:0]  pi  [0:1023];
   logic [31:0] ed  [0:2047];
   int          pcnt = 0, ecnt = 0, cyc = 0, e_first = 0, e_last = 0;
   int          fp_done_pc = 0, bp_done_ec = 0;
   logic        prev_ev = 1'b0, fp_done_rdy = 1'b0;

   // Output recorder
   always @(negedge clk) begin
      cyc     <= cyc + 1;
      prev_ev <= err_out_valid;
      if (pool_valid) begin
         if (pcnt < 1024) begin
            pd[pcnt] <= pool_data;
            pi[pcnt] <= pool_idx;
         end
         pcnt <= pcnt + 1;
      end
      if (done_FP) begin
         fp_done_pc  <= pcnt + int'(pool_valid);
         fp_done_rdy <= in_ready;
      end
      if (err_out_valid) begin
         if (ecnt < 2048) ed[ecnt] <= err_out_data;
         ecnt <= ecnt + 1;
         if (!prev_ev) e_first <= cyc;
         e_last <= cyc;
      end
      if (done_BP) bp_done_ec <= ecnt + int'(err_out_valid);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] itof(input int n);
      int          e;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      m = n << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   function automatic longint fkey(input logic [31:0] v);
      longint m;
      m = longint'(v[30:0]);
      return v[31] ? -m : m;
   endfunction

   // Reference window: earliest position holding the maximum key.
   function automatic logic [33:0] model_win(input int w);
      int p0, best;
      int cand [4];
      p0 = (w / 14) * 56 + (w % 14) * 2;
      cand[0] = p0; cand[1] = p0 + 1; cand[2] = p0 + 28; cand[3] = p0 + 29;
      best = 0;
      for (int i = 1; i < 4; i++)
         if (fkey(img[cand[i]]) > fkey(img[cand[best]])) best = i;
      return {2'(best), img[cand[best]]};
   endfunction

   function automatic logic [31:0] exp_err(input int p);
      int          r, c, w, pos;
      logic [33:0] m;
      r = p / 28; c = p % 28;
      w = (r / 2) * 14 + c / 2;
      pos = (r % 2) * 2 + (c % 2);
      m = model_win(w);
      return (int'(m[33:32]) == pos) ? itof(w + 1) : 32'h0;
   endfunction

   task automatic pulse(input bit f, input bit b);
      start_fp = f; start_bp = b;
      @(posedge clk); @(negedge clk);
      start_fp = 1'b0; start_bp = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"},      32'(in_ready), 32'h0);
      check({tag, "_pool_valid"},    32'(pool_valid), 32'h0);
      check({tag, "_pool_data"},     pool_data, 32'h0);
      check({tag, "_pool_idx"},      32'(pool_idx), 32'h0);
      check({tag, "_err_out_valid"}, 32'(err_out_valid), 32'h0);
      check({tag, "_err_out_data"},  err_out_data, 32'h0);
      check({tag, "_done_FP"},       32'(done_FP), 32'h0);
      check({tag, "_done_BP"},       32'(done_BP), 32'h0);
   endtask

   // Feeds img; bad counts cycles where pool_valid differs from the expected pulse.
   task automatic feed_fp(input bit stall, output int bad);
      int gaps;
      bad = 0;
      for (int p = 0; p < 784; p++) begin
         gaps = stall ? int'($urandom_range(0, 1)) : 0;
         repeat (gaps) begin
            in_valid = 1'b0;
            @(posedge clk); @(negedge clk);
            if (pool_valid !== 1'b0) bad++;
         end
         in_valid = 1'b1; in_data = img[p];
         @(posedge clk); @(negedge clk);
         if (pool_valid !== (((p / 28) % 2 == 1) && ((p % 28) % 2 == 1))) bad++;
      end
      in_valid = 1'b0;
   endtask

   task automatic feed_err(input int n);
      for (int w = 0; w < n; w++) begin
         if (w % 50 == 7) begin
            err_in_valid = 1'b0;
            @(posedge clk); @(negedge clk);
         end
         err_in_valid = 1'b1; err_in_data = itof(w + 1);
         @(posedge clk); @(negedge clk);
      end
      err_in_valid = 1'b0;
   endtask

   task automatic fp_pass(input string nm, input bit both, input bit stall, output int base);
      int bad;
      base = pcnt;
      pulse(1'b1, both);
      check({nm, "_ready_rise"}, 32'(in_ready), 32'h1);
      feed_fp(stall, bad);
      check({nm, "_done_FP"}, 32'(done_FP), 32'h1);
      check({nm, "_ready_low_at_done"}, 32'(in_ready), 32'h0);
      check({nm, "_pool_pulse_timing"}, bad, 0);
      @(negedge clk);
      check({nm, "_done_FP_one_cycle"}, 32'(done_FP), 32'h0);
      repeat (2) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 196; k++) begin
         logic [33:0] m;
         m = model_win(k);
         if (pd[base + k] !== m[31:0] || pi[base + k] !== m[33:32]) bad++;
      end
      check({nm, "_window_errors"}, bad, 0);
      check({nm, "_pool_count"}, pcnt - base, 196);
      check({nm, "_done_with_last_pool"}, fp_done_pc - base, 196);
   endtask

   task automatic bp_pass(input string nm, input bit poke_fp, output int base);
      int bad, nz;
      base = ecnt;
      pulse(1'b0, 1'b1);
      check({nm, "_ready_rise"}, 32'(in_ready), 32'h1);
      feed_err(196);
      repeat (5) @(negedge clk);
      if (poke_fp) pulse(1'b1, 1'b0);
      for (int i = 0; i < 2000 && ecnt < base + 784; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({nm, "_idle_after"}, 32'(in_ready), 32'h0);
      bad = 0; nz = 0;
      for (int p = 0; p < 784; p++) begin
         if (ed[base + p] !== exp_err(p)) bad++;
         if (ed[base + p] != 32'h0) nz++;
      end
      check({nm, "_pixel_errors"}, bad, 0);
      check({nm, "_nonzero_count"}, nz, 196);
      check({nm, "_out_count"}, ecnt - base, 784);
      check({nm, "_contiguous_span"}, e_last - e_first, 783);
      check({nm, "_done_with_last"}, bp_done_ec - base, 784);
   endtask

   initial begin
      int b;
      for (int p = 0; p < 784; p++) img[p] = itof(p);

      // Reset values, then reset during a partial forward pass
      repeat (3) @(negedge clk);
      check_zero("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      check_zero("after_rst");
      pulse(1'b1, 1'b0);
      check("partial_ready", 32'(in_ready), 32'h1);
      for (int p = 0; p < 30; p++) begin
         in_valid = 1'b1; in_data = img[p];
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      check("partial_pool_valid", 32'(pool_valid), 32'h1);
      check("partial_pool_data", pool_data, 32'h41E8_0000);
      check("partial_pool_idx", 32'(pool_idx), 32'h3);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check_zero("mid_fp_rst");
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      pulse(1'b0, 1'b1);
      check("bp_without_fp_ignored", 32'(in_ready), 32'h0);
      repeat (3) @(negedge clk);
      check("bp_without_fp_ignored_late", 32'(in_ready), 32'h0);

      // Unstalled ramp
      fp_pass("fp1", 1'b0, 1'b0, b);
      check("fp1_win0_data", pd[b], 32'h41E8_0000);
      check("fp1_win0_idx", 32'(pi[b]), 32'h3);
      check("fp1_win195_data", pd[b + 195], 32'h4443_C000);
      check("fp1_win195_idx", 32'(pi[b + 195]), 32'h3);

      // Backward pass over ramp argmax, start_fp poked mid-emit
      bp_pass("bp1", 1'b1, b);
      check("bp1_px_1_1", ed[b + 29], 32'h3F80_0000);
      check("bp1_px_0_0", ed[b + 0], 32'h0);
      check("bp1_px_0_1", ed[b + 1], 32'h0);
      check("bp1_px_1_0", ed[b + 28], 32'h0);
      check("bp1_px_27_27", ed[b + 783], 32'h4344_0000);

      // Simultaneous starts with fp_complete set, stalled ramp
      fp_pass("fp2", 1'b1, 1'b1, b);

      // Negatives, signed zeros, ties, right-wins
      img[0] = 32'hBF80_0000; img[1] = 32'hC000_0000; img[28] = 32'hBF00_0000; img[29] = 32'hC040_0000;
      img[2] = 32'h0000_0000; img[3] = 32'h8000_0000; img[30] = 32'h0000_0000; img[31] = 32'h0000_0000;
      img[4] = 32'h40A0_0000; img[5] = 32'h40A0_0000; img[32] = 32'h40A0_0000; img[33] = 32'h40A0_0000;
      img[6] = 32'h3F80_0000; img[7] = 32'h4040_0000; img[34] = 32'h4000_0000; img[35] = 32'h4020_0000;
      fp_pass("fp3", 1'b0, 1'b0, b);
      check("fp3_neg_data", pd[b], 32'hBF00_0000);
      check("fp3_neg_idx", 32'(pi[b]), 32'h2);
      check("fp3_zero_data", pd[b + 1], 32'h0);
      check("fp3_zero_idx", 32'(pi[b + 1]), 32'h0);
      check("fp3_tie_data", pd[b + 2], 32'h40A0_0000);
      check("fp3_tie_idx", 32'(pi[b + 2]), 32'h0);
      check("fp3_tr_data", pd[b + 3], 32'h4040_0000);
      check("fp3_tr_idx", 32'(pi[b + 3]), 32'h1);

      bp_pass("bp2", 1'b0, b);
      check("bp2_px_1_0", ed[b + 28], 32'h3F80_0000);
      check("bp2_px_1_1", ed[b + 29], 32'h0);
      check("bp2_px_0_7", ed[b + 7], 32'h4080_0000);

      // Reset during BP_LOAD clears fp_complete
      pulse(1'b0, 1'b1);
      check("bp3_ready", 32'(in_ready), 32'h1);
      feed_err(10);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check_zero("mid_bp_rst");
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      pulse(1'b0, 1'b1);
      check("bp_after_rst_ignored", 32'(in_ready), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pa_maxpool_unit.md
# pa_maxpool_unit

Streaming 2x2/stride-2 max-pool stage that sits directly downstream of the parallel-adapter top module. In forward pass it consumes one channel of adapter-summed activations (28x28, IEEE-754 single, raster order) and emits the 14x14 pooled map, recording the argmax position of every window. In backward pass it accepts the 14x14 pooled-layer error and expands it to the 28x28 error that drives the adapter's `error_IN` bus, routing each error to its recorded argmax and zeroing the other three positions.

## Interface
- `BIT_WIDTH`, 32, word width (IEEE-754 single)
- `IMG_W`, 28, input width in pixels, must be even
- `IMG_H`, 28, input height in pixels, must be even
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_fp`  in  1  one-cycle pulse; begins forward pass
- `start_bp`  in  1  one-cycle pulse; begins backward pass
- `in_valid`  in  1  activation sample valid (FP_RUN)
- `in_data`  in  BIT_WIDTH  activation sample
- `err_in_valid`  in  1  pooled-error sample valid (BP_LOAD)
- `err_in_data`  in  BIT_WIDTH  pooled-error sample, raster order over 14x14
- `in_ready`  out  1  high in FP_RUN and BP_LOAD
- `pool_valid`  out  1  pooled output valid
- `pool_data`  out  BIT_WIDTH  pooled max value
- `pool_idx`  out  2  argmax of window: 0 TL, 1 TR, 2 BL, 3 BR
- `err_out_valid`  out  1  expanded-error sample valid
- `err_out_data`  out  BIT_WIDTH  expanded error, raster order over 28x28
- `done_FP`  out  1  one-cycle pulse, forward pass complete
- `done_BP`  out  1  one-cycle pulse, backward pass complete

## Operation
- States: IDLE, FP_RUN, BP_LOAD, BP_EMIT.
- IDLE: `start_fp` -> FP_RUN, clears `fp_complete` flag, zeroes row/col counters. `start_bp` -> BP_LOAD only if `fp_complete`=1; otherwise ignored. Both asserted together: `start_fp` wins.
- Starts in any non-IDLE state are ignored.
- FP_RUN: accepts a sample on each cycle `in_valid`=1; counters advance row-major, col wraps at IMG_W-1, row at IMG_H-1.
  - Even row, odd col: max of pair (col-1, col) stored in line buffer entry col/2 with 1-bit horizontal index.
  - Odd row, odd col: max of bottom pair compared with stored top pair; result and 2-bit index written to argmax memory (IMG_W/2*IMG_H/2 entries x 2 bits) and presented on `pool_*`.
  - After sample IMG_W*IMG_H accepted: set `fp_complete`, -> IDLE.
- Compare: sign-magnitude on raw bits; +0 and -0 equal; NaN inputs out of scope. Ties resolve to earlier position (TL > TR > BL > BR priority, left before right in pairs).
- BP_LOAD: accepts (IMG_W/2)*(IMG_H/2) errors into error buffer on `err_in_valid`; after last -> BP_EMIT.
- BP_EMIT: one output per cycle, no stalls, IMG_W*IMG_H cycles. For pixel (r,c): window w=(r/2)*(IMG_W/2)+c/2, pos={r[0],c[0]}; `err_out_data` = err_buf[w] if argmax[w]==pos else 32'h0. After last -> IDLE; `fp_complete` stays set (BP may be repeated).
- Argmax and error buffers are not cleared by reset; contents irrelevant since `fp_complete` resets to 0.

## Timing
- Reset values: `in_ready`, `pool_valid`, `err_out_valid`, `done_FP`, `done_BP` = 0; `pool_data`, `err_out_data` = 0; `pool_idx` = 0; state IDLE; `fp_complete` = 0.
- `in_ready` rises the cycle after the start pulse is sampled.
- `pool_valid` asserts exactly 1 cycle after the odd-row/odd-col sample is accepted; 1-cycle pulse per window; `pool_data`/`pool_idx` hold until next window.
- `done_FP` coincides with the final `pool_valid`; `in_ready` low that same cycle.
- First `err_out_valid` 1 cycle after entering BP_EMIT; contiguous for IMG_W*IMG_H cycles; `done_BP` coincides with the last.
- Gaps in `in_valid`/`err_in_valid` only stall counters; no data loss.
- `rst` mid-operation: next cycle IDLE, all outputs at reset values, partial pass discarded.

## Test plan
- Reset: hold `rst` 2 cycles during FP_RUN -> all outputs 0, `start_bp` afterwards ignored (no `in_ready`).
- FP ramp: in_data = float(r*28+c) -> 196 `pool_valid` pulses, window (0,0) = 29.0 idx 3, window (13,13) = 783.0 idx 3, `done_FP` with 196th pulse.
- Negatives/ties: window {-1.0,-2.0,-0.5,-3.0} -> -0.5 idx 2; window {+0,-0,+0,+0} -> idx 0; window {5.0,5.0,5.0,5.0} -> idx 0.
- BP routing: after ramp FP, err_in = float(w+1) -> 784 outputs; pixel (1,1)=1.0, (0,0)=(0,1)=(1,0)=0.0, pixel (27,27)=196.0; exactly 196 nonzero; `done_BP` on 784th.
- Stalls: `in_valid` toggled 1/0 pseudo-randomly during FP -> pooled outputs identical to unstalled ramp run.
- Start arbitration: `start_fp` and `start_bp` same cycle from IDLE with `fp_complete`=1 -> FP_RUN entered, `fp_complete` cleared; `start_fp` during BP_EMIT ignored.
